sdn_deparser_insertion_unit: RTL and testbench

SDN_DEPARSER_INSERTION_UNIT -- requirements
Module: sdn_deparser_insertion_unit

---
 rtl/sdn_deparser_insertion_unit.sv | 174 +++++++++++++++++
 tb/tb_sdn_deparser_insertion_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdn_deparser_insertion_unit.sv
// Deparser field insertion: overlays right-aligned header fields onto packet
// words at absolute bit offsets, carrying boundary-crossing bits to the next word.
module sdn_deparser_insertion_unit #(
   parameter int PRS_DATA_W       = 512,
   parameter int PRS_OFFSET_W     = 32,
   parameter int HEAD_FIELD_LEN_W = 9
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        ins_unit_en_i,
   input  logic                        ins_unit_flush_i,
   input  logic                        word_valid_i,
   output logic                        word_ready_o,
   input  logic [PRS_DATA_W-1:0]       word_data_i,
   input  logic                        word_last_i,
   input  logic                        field_valid_i,
   output logic                        field_ready_o,
   input  logic [PRS_DATA_W-1:0]       field_data_i,
   input  logic [HEAD_FIELD_LEN_W-1:0] field_len_i,
   input  logic [PRS_OFFSET_W-1:0]     field_offset_i,
   input  logic                        field_last_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [PRS_DATA_W-1:0]       out_data_o,
   output logic                        out_last_o,
   output logic                        err_o
);
   localparam int W   = PRS_DATA_W;
   localparam int LW2 = $clog2(PRS_DATA_W);
   localparam int SW  = LW2 + 2;

   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

   state_t                  state_q, state_d;
   logic [W-1:0]            buf_q, buf_d;
   logic [PRS_OFFSET_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]            spill_q, spill_d;
   logic [LW2-1:0]          spill_len_q, spill_len_d;
   logic                    spill_vld_q, spill_vld_d;
   logic                    done_q, done_d;
   logic                    last_q, last_d;
   logic                    err_q, err_d;

   logic [PRS_OFFSET_W-1:0] f_idx;
   logic [LW2-1:0]          f_off;
   logic [SW-1:0]           f_end, f_sh;
   logic [W-1:0]            len_mask, spill_mask;
   logic [2*W-1:0]          wide_data, wide_mask;
   logic                    f_len0, f_bad_len, f_cross;
   logic                    word_acc, field_acc;

   // Field placed in a two-word window: upper half hits the current word,
   // lower half is already aligned to the next word's MSBs.
   assign f_idx      = field_offset_i >> LW2;
   assign f_off      = field_offset_i[LW2-1:0];
   assign f_len0     = (field_len_i == '0);
   assign f_bad_len  = (32'(field_len_i) > W - 1);
   assign f_end      = SW'(f_off) + SW'(field_len_i);
   assign f_sh       = SW'(2 * W) - f_end;
   assign f_cross    = (f_end > SW'(W));
   assign len_mask   = ~({W{1'b1}} << field_len_i);
   assign wide_data  = {{W{1'b0}}, field_data_i & len_mask} << f_sh;
   assign wide_mask  = {{W{1'b0}}, len_mask} << f_sh;
   assign spill_mask = ~({W{1'b1}} >> spill_len_q);

   assign word_ready_o  = resetn && (state_q == IDLE) &&
                          ins_unit_en_i && !ins_unit_flush_i;
   assign field_ready_o = resetn && (state_q == LOAD) &&
                          ins_unit_en_i && !ins_unit_flush_i &&
                          !done_q && field_valid_i &&
                          (f_len0 || f_bad_len || f_idx <= cnt_q);
   assign word_acc  = word_valid_i && word_ready_o;
   assign field_acc = field_valid_i && field_ready_o;

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      spill_d     = spill_q;
      spill_len_d = spill_len_q;
      spill_vld_d = spill_vld_q;
      done_d      = done_q;
      last_d      = last_q;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (word_acc) begin
               buf_d = spill_vld_q ?
                       ((word_data_i & ~spill_mask) | spill_q) :
                       word_data_i;
               spill_vld_d = 1'b0;
               last_d      = word_last_i;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            if (done_q) begin
               state_d = EMIT;
            end else if (field_acc) begin
               done_d = field_last_i;
               if (f_len0) begin
                  done_d = field_last_i;
               end else if (f_bad_len || f_idx < cnt_q) begin
                  err_d = 1'b1;
               end else begin
                  buf_d = (buf_q & ~wide_mask[2*W-1:W]) |
                          wide_data[2*W-1:W];
                  if (f_cross) begin
                     spill_d     = wide_data[W-1:0];
                     spill_len_d = LW2'(f_end - SW'(W));
                     spill_vld_d = 1'b1;
                     state_d     = EMIT;
                  end
               end
            end else if (field_valid_i && !f_len0 && !f_bad_len &&
                         f_idx > cnt_q) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready_i) begin
               state_d = IDLE;
               if (last_q) begin
                  cnt_d       = '0;
                  done_d      = 1'b0;
                  spill_vld_d = 1'b0;
                  err_d       = spill_vld_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over every handshake in flight.
      if (ins_unit_flush_i) begin
         state_d     = IDLE;
         cnt_d       = '0;
         spill_vld_d = 1'b0;
         done_d      = 1'b0;
         err_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         spill_q     <= '0;
         spill_len_q <= '0;
         spill_vld_q <= 1'b0;
         done_q      <= 1'b0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         spill_q     <= spill_d;
         spill_len_q <= spill_len_d;
         spill_vld_q <= spill_vld_d;
         done_q      <= done_d;
         last_q      <= last_d;
         err_q       <= err_d;
      end
   end

   assign out_valid_o = (state_q == EMIT);
   assign out_data_o  = buf_q;
   assign out_last_o  = last_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_sdn_deparser_insertion_unit.sv
// Bench for sdn_deparser_insertion_unit: directed scenarios plus random
// packets checked against a bit-level packet model.
module tb_sdn_deparser_insertion_unit;
   localparam int W  = 512;
   localparam int OW = 32;
   localparam int LW = 9;

   logic          clk = 1'b0;
   logic          resetn;
   logic          ins_unit_en_i;
   logic          ins_unit_flush_i;
   logic          word_valid_i;
   logic          word_ready_o;
   logic [W-1:0]  word_data_i;
   logic          word_last_i;
   logic          field_valid_i;
   logic          field_ready_o;
   logic [W-1:0]  field_data_i;
   logic [LW-1:0] field_len_i;
   logic [OW-1:0] field_offset_i;
   logic          field_last_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [W-1:0]  out_data_o;
   logic          out_last_o;
   logic          err_o;

   always #5 clk = ~clk;

   sdn_deparser_insertion_unit dut (
      .clk(clk), .resetn(resetn),
      .ins_unit_en_i(ins_unit_en_i), .ins_unit_flush_i(ins_unit_flush_i),
      .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
      .word_data_i(word_data_i), .word_last_i(word_last_i),
      .field_valid_i(field_valid_i), .field_ready_o(field_ready_o),
      .field_data_i(field_data_i), .field_len_i(field_len_i),
      .field_offset_i(field_offset_i), .field_last_i(field_last_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o), .err_o(err_o)
   );

   typedef struct {
      int           off;
      int           len;
      logic [W-1:0] data;
      bit           last;
   } fld_t;

   int           checks = 0;
   int           errors = 0;
   bit           tmo;
   logic [W-1:0] in_words[$];
   fld_t         flds[$];
   logic [W-1:0] exp_words[$];
   int           exp_err;
   logic [W-1:0] got_data[$];
   bit           got_last[$];
   int           got_err;

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] v;
      for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   // Packet viewed as a flat bit string; bit k lives in word k/W at W-1-k%W.
   task automatic model_run();
      int  c;
      bit  lost;
      c = 0;
      lost = 0;
      exp_err = 0;
      exp_words.delete();
      foreach (in_words[i]) exp_words.push_back(in_words[i]);
      foreach (flds[f]) begin
         int idx;
         idx = flds[f].off / W;
         if (flds[f].len == 0) continue;
         if (flds[f].len > W - 1) begin exp_err++; continue; end
         if (idx > c) c = idx;
         if (idx < c) begin exp_err++; continue; end
         for (int i = 0; i < flds[f].len; i++) begin
            int k;
            logic [W-1:0] t;
            k = flds[f].off + i;
            if (k / W < exp_words.size()) begin
               t = exp_words[k / W];
               t[W - 1 - (k % W)] = flds[f].data[flds[f].len - 1 - i];
               exp_words[k / W] = t;
            end else begin
               lost = 1;
            end
         end
         if ((flds[f].off % W) + flds[f].len > W) c++;
      end
      if (lost) exp_err++;
   endtask

   task automatic put_word(input logic [W-1:0] d, input logic l);
      logic acc;
      acc = 1'b0;
      word_valid_i = 1'b1;
      word_data_i  = d;
      word_last_i  = l;
      for (int n = 0; n < 200 && !acc; n++) begin
         #1 acc = word_ready_o;
         @(negedge clk);
      end
      word_valid_i = 1'b0;
      if (!acc) tmo = 1;
   endtask

   task automatic put_field(input int off, input int len,
                            input logic [W-1:0] d, input logic l);
      logic acc;
      acc = 1'b0;
      field_valid_i  = 1'b1;
      field_offset_i = OW'(off);
      field_len_i    = LW'(len);
      field_data_i   = d;
      field_last_i   = l;
      for (int n = 0; n < 200 && !acc; n++) begin
         #1 acc = field_ready_o;
         @(negedge clk);
      end
      field_valid_i = 1'b0;
      if (!acc) tmo = 1;
   endtask

   task automatic run_pkt(input int rdy_pct);
      got_data.delete();
      got_last.delete();
      got_err = 0;
      fork
         begin
            foreach (in_words[i]) begin
               while ($urandom_range(0, 3) == 0) @(negedge clk);
               put_word(in_words[i], (i == in_words.size() - 1));
            end
         end
         begin
            foreach (flds[f]) begin
               while ($urandom_range(0, 3) == 0) @(negedge clk);
               put_field(flds[f].off, flds[f].len, flds[f].data,
                         flds[f].last);
            end
         end
         begin
            int cyc;
            cyc = 0;
            while (got_data.size() < in_words.size() && cyc < 3000) begin
               out_ready_i = ($urandom_range(0, 99) < rdy_pct);
               #1;
               if (err_o) got_err++;
               if (out_valid_o && out_ready_i) begin
                  got_data.push_back(out_data_o);
                  got_last.push_back(out_last_o);
               end
               @(negedge clk);
               cyc++;
            end
            out_ready_i = 1'b0;
            repeat (3) begin
               #1;
               if (err_o) got_err++;
               @(negedge clk);
            end
            if (cyc >= 3000) tmo = 1;
         end
      join
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      ins_unit_en_i = 1'b1;
      ins_unit_flush_i = 1'b0;
      word_valid_i = 1'b0;
      word_data_i = '0;
      word_last_i = 1'b0;
      field_valid_i = 1'b0;
      field_data_i = '0;
      field_len_i = '0;
      field_offset_i = '0;
      field_last_i = 1'b0;
      out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", out_valid_o); end
      checks++; if (out_data_o !== '0) begin errors++; $display("FAIL rst_data got=%h want=0", out_data_o); end
      checks++; if (out_last_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rst_last_err got=%b%b want=00", out_last_o, err_o); end
      resetn = 1'b1;
      #1;
      checks++; if (word_ready_o !== 1'b1) begin errors++; $display("FAIL rst_wready got=%b want=1", word_ready_o); end
      checks++; if (field_ready_o !== 1'b0) begin errors++; $display("FAIL rst_fready got=%b want=0", field_ready_o); end
      @(negedge clk);
   endtask

   task automatic test_single_field();
      tmo = 0;
      in_words.delete(); flds.delete();
      in_words.push_back('0);
      flds.push_back('{off: 8, len: 16, data: W'(16'hABCD), last: 1'b1});
      model_run();
      run_pkt(100);
      checks++; if (tmo || got_data.size() != 1) begin errors++; $display("FAIL single_cnt got=%0d want=1 tmo=%0b", got_data.size(), tmo); end
      foreach (got_data[i]) begin
         checks++; if (got_data[i] !== exp_words[i]) begin errors++; $display("FAIL single_data w%0d got=%h want=%h", i, got_data[i], exp_words[i]); end
         checks++; if (got_data[i][503:488] !== 16'hABCD) begin errors++; $display("FAIL single_bits got=%h want=abcd", got_data[i][503:488]); end
         checks++; if (got_last[i] !== 1'b1) begin errors++; $display("FAIL single_last got=%b want=1", got_last[i]); end
      end
      checks++; if (got_err != 0) begin errors++; $display("FAIL single_err got=%0d want=0", got_err); end
   endtask

   task automatic test_spill();
      tmo = 0;
      in_words.delete(); flds.delete();
      in_words.push_back('0);
      in_words.push_back('0);
      flds.push_back('{off: 504, len: 16, data: W'(16'h1234), last: 1'b1});
      model_run();
      run_pkt(70);
      checks++; if (tmo || got_data.size() != 2) begin errors++; $display("FAIL spill_cnt got=%0d want=2 tmo=%0b", got_data.size(), tmo); end
      foreach (got_data[i]) begin
         checks++; if (got_data[i] !== exp_words[i]) begin errors++; $display("FAIL spill_data w%0d got=%h want=%h", i, got_data[i], exp_words[i]); end
         checks++; if (got_last[i] !== (i == 1)) begin errors++; $display("FAIL spill_last w%0d got=%b", i, got_last[i]); end
      end
      if (got_data.size() == 2) begin
         checks++; if (got_data[0][7:0] !== 8'h12) begin errors++; $display("FAIL spill_lo got=%h want=12", got_data[0][7:0]); end
         checks++; if (got_data[1][511:504] !== 8'h34) begin errors++; $display("FAIL spill_hi got=%h want=34", got_data[1][511:504]); end
      end
      checks++; if (got_err != 0) begin errors++; $display("FAIL spill_err got=%0d want=0", got_err); end
   endtask

   task automatic test_drop();
      tmo = 0;
      in_words.delete(); flds.delete();
      in_words.push_back('0);
      in_words.push_back('0);
      flds.push_back('{off: 600, len: 16, data: W'(16'hBEEF), last: 1'b0});
      flds.push_back('{off: 100, len: 8, data: W'(8'h5A), last: 1'b1});
      model_run();
      run_pkt(80);
      checks++; if (tmo || got_data.size() != 2) begin errors++; $display("FAIL drop_cnt got=%0d want=2 tmo=%0b", got_data.size(), tmo); end
      foreach (got_data[i]) begin
         checks++; if (got_data[i] !== exp_words[i]) begin errors++; $display("FAIL drop_data w%0d got=%h want=%h", i, got_data[i], exp_words[i]); end
      end
      if (got_data.size() == 2) begin
         checks++; if (got_data[1][423:408] !== 16'hBEEF) begin errors++; $display("FAIL drop_w1 got=%h want=beef", got_data[1][423:408]); end
         checks++; if (got_data[0] !== '0) begin errors++; $display("FAIL drop_w0 got=%h want=0", got_data[0]); end
      end
      checks++; if (got_err != 1) begin errors++; $display("FAIL drop_err got=%0d want=1", got_err); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d, ex, held;
      tmo = 0;
      d = rnd_word();
      out_ready_i = 1'b0;
      put_word(d, 1'b1);
      put_field(40, 8, W'(8'hC3), 1'b1);
      ex = d;
      ex[471 -: 8] = 8'hC3;
      @(negedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b want=1", out_valid_o); end
      checks++; if (out_data_o !== ex) begin errors++; $display("FAIL bp_data got=%h want=%h", out_data_o, ex); end
      held = out_data_o;
      word_valid_i = 1'b1;
      word_data_i  = rnd_word();
      word_last_i  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         checks++; if (out_valid_o !== 1'b1 || out_data_o !== held) begin errors++; $display("FAIL bp_hold got=%b/%h want=1/%h", out_valid_o, out_data_o, held); end
         checks++; if (word_ready_o !== 1'b0) begin errors++; $display("FAIL bp_wready got=%b want=0", word_ready_o); end
      end
      word_valid_i  = 1'b0;
      ins_unit_en_i = 1'b0;
      out_ready_i   = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_done_dis got=%b want=0", out_valid_o); end
      checks++; if (word_ready_o !== 1'b0) begin errors++; $display("FAIL bp_en_block got=%b want=0", word_ready_o); end
      ins_unit_en_i = 1'b1;
      out_ready_i   = 1'b0;
      #1;
      checks++; if (word_ready_o !== 1'b1) begin errors++; $display("FAIL bp_en_restore got=%b want=1", word_ready_o); end
      checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got=1 want=0"); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      tmo = 0;
      out_ready_i = 1'b0;
      put_word('0, 1'b1);
      ins_unit_flush_i = 1'b1;
      @(negedge clk);
      ins_unit_flush_i = 1'b0;
      #1;
      checks++; if (out_valid_o !== 1'b0 || word_ready_o !== 1'b1) begin errors++; $display("FAIL flush_load got=%b/%b want=0/1", out_valid_o, word_ready_o); end
      @(negedge clk);
      put_word('0, 1'b0);
      put_field(504, 16, W'(16'h1234), 1'b1);
      #1;
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre got=%b want=1", out_valid_o); end
      ins_unit_flush_i = 1'b1;
      @(negedge clk);
      ins_unit_flush_i = 1'b0;
      #1;
      checks++; if (out_valid_o !== 1'b0 || word_ready_o !== 1'b1) begin errors++; $display("FAIL flush_emit got=%b/%b want=0/1", out_valid_o, word_ready_o); end
      @(negedge clk);
      in_words.delete(); flds.delete();
      in_words.push_back('0);
      flds.push_back('{off: 8, len: 16, data: W'(16'hABCD), last: 1'b1});
      model_run();
      run_pkt(100);
      checks++; if (tmo || got_data.size() != 1) begin errors++; $display("FAIL flush_cnt got=%0d want=1 tmo=%0b", got_data.size(), tmo); end
      foreach (got_data[i]) begin
         checks++; if (got_data[i] !== exp_words[i]) begin errors++; $display("FAIL flush_next got=%h want=%h", got_data[i], exp_words[i]); end
         checks++; if (got_data[i][511:504] !== 8'h00) begin errors++; $display("FAIL flush_spill got=%h want=00", got_data[i][511:504]); end
      end
      checks++; if (got_err != 0) begin errors++; $display("FAIL flush_err got=%0d want=0", got_err); end
   endtask

   task automatic test_reset_mid_emit();
      tmo = 0;
      out_ready_i = 1'b0;
      put_word(rnd_word(), 1'b1);
      put_field(16, 32, rnd_word(), 1'b1);
      @(negedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rme_pre got=%b want=1", out_valid_o); end
      resetn = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rme_ctl got=%b%b%b want=000", out_valid_o, out_last_o, err_o); end
      checks++; if (out_data_o !== '0) begin errors++; $display("FAIL rme_data got=%h want=0", out_data_o); end
      checks++; if (word_ready_o !== 1'b0 || field_ready_o !== 1'b0) begin errors++; $display("FAIL rme_rdy got=%b%b want=00", word_ready_o, field_ready_o); end
      resetn = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (word_ready_o !== 1'b1 || field_ready_o !== 1'b0) begin errors++; $display("FAIL rme_release got=%b%b want=10", word_ready_o, field_ready_o); end
      checks++; if (tmo) begin errors++; $display("FAIL rme_timeout got=1 want=0"); end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int p = 0; p < 25; p++) begin
         int nw, nf, cur, lim;
         tmo = 0;
         in_words.delete(); flds.delete();
         nw  = $urandom_range(1, 4);
         nf  = $urandom_range(1, 5);
         lim = nw * W - 1;
         for (int i = 0; i < nw; i++)
            in_words.push_back(($urandom_range(0, 2) == 0) ? '0 : rnd_word());
         cur = $urandom_range(0, 200);
         for (int f = 0; f < nf; f++) begin
            fld_t fl;
            fl.off = (f > 0 && $urandom_range(0, 5) == 0) ?
                     $urandom_range(0, cur) : cur;
            if (fl.off > lim) fl.off = lim;
            fl.len = ($urandom_range(0, 9) == 0) ?
                     $urandom_range(0, W - 1) : $urandom_range(0, 64);
            fl.data = rnd_word();
            // a field running past the packet end must close the field list
            fl.last = (f == nf - 1) || (fl.off + fl.len > nw * W);
            flds.push_back(fl);
            if (fl.last) break;
            cur = fl.off + fl.len + $urandom_range(0, 400);
            if (cur > lim) cur = lim;
         end
         model_run();
         run_pkt($urandom_range(30, 100));
         checks++; if (tmo || got_data.size() != nw) begin errors++; $display("FAIL rnd%0d_cnt got=%0d want=%0d tmo=%0b", p, got_data.size(), nw, tmo); end
         foreach (got_data[i]) begin
            checks++; if (got_data[i] !== exp_words[i]) begin errors++; $display("FAIL rnd%0d_data w%0d got=%h want=%h", p, i, got_data[i], exp_words[i]); end
            checks++; if (got_last[i] !== (i == nw - 1)) begin errors++; $display("FAIL rnd%0d_last w%0d got=%b", p, i, got_last[i]); end
         end
         checks++; if (got_err != exp_err) begin errors++; $display("FAIL rnd%0d_err got=%0d want=%0d", p, got_err, exp_err); end
      end
   endtask

   initial begin
      test_reset();
      test_single_field();
      test_spill();
      test_drop();
      test_backpressure();
      test_flush();
      test_reset_mid_emit();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
